// File: rtl/line_raster_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_raster_if
// Command and pixel channels of the line rasteriser, each with a
// ready/ready handshake.
// Revision: 1.0
// ---------------------------------------------------------------------------

// Line command channel: decoder (master) -> rasteriser (slave)
interface line_cmd_if #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 12,
  parameter int PAT_W   = 16
);
  logic [COORD_W-1:0] x0_in;
  logic [COORD_W-1:0] y0_in;
  logic [COORD_W-1:0] x1_in;
  logic [COORD_W-1:0] y1_in;
  logic [COLOR_W-1:0] color_in;
  logic [PAT_W-1:0]   pattern_in;
  logic               dash_en;
  logic               in_rts;
  logic               in_rtr;

  modport master (
    output x0_in, y0_in, x1_in, y1_in, color_in, pattern_in, dash_en, in_rts,
    input  in_rtr
  );

  modport slave (
    input  x0_in, y0_in, x1_in, y1_in, color_in, pattern_in, dash_en, in_rts,
    output in_rtr
  );
endinterface

// Pixel channel: rasteriser (master) -> framebuffer write arbiter (slave)
interface line_pix_if #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 12
);
  logic               out_rts;
  logic               out_rtr;
  logic [COORD_W-1:0] draw_x;
  logic [COORD_W-1:0] draw_y;
  logic [COLOR_W-1:0] color_out;

  modport master (
    output out_rts, draw_x, draw_y, color_out,
    input  out_rtr
  );

  modport slave (
    input  out_rts, draw_x, draw_y, color_out,
    output out_rtr
  );
endinterface

`default_nettype wire

// File: rtl/line_raster.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_raster
// All-octant integer Bresenham line rasteriser with screen clipping and an
// optional rotating dash pattern. One segment per command transfer, one
// pixel per cycle when the downstream is ready.
// Revision: 1.0
// ---------------------------------------------------------------------------
module line_raster #(
  parameter int COORD_W  = 10,
  parameter int COLOR_W  = 12,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int PAT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_,
  line_cmd_if.slave  cmd,
  line_pix_if.master pix,
  output logic       busy,
  output logic       done
);

  localparam logic [31:0] X_LIM = 32'(SCREEN_W);
  localparam logic [31:0] Y_LIM = 32'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Latched command
  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [COLOR_W-1:0] color_q;
  logic [PAT_W-1:0]   pat_q;
  logic               dash_q;

  // Walk state
  logic [COORD_W:0]          dx_q, dy_q;
  logic                      sx_neg, sy_neg;
  logic signed [COORD_W+1:0] err_q;
  logic [COORD_W-1:0]        cur_x, cur_y;

  // Registered handshake / status outputs
  logic out_rts_q, in_rtr_q, busy_q, done_q;

  // Combinational helpers
  logic [COORD_W:0]          setup_dx, setup_dy;
  logic signed [COORD_W+2:0] e2, neg_dy, dx_wide;
  logic signed [COORD_W+1:0] dx_s, dy_s, next_err;
  logic [COORD_W-1:0]        next_x, next_y;
  logic [PAT_W-1:0]          pat_rot;
  logic                      go_x, go_y, at_end, step_ev, in_xfc;
  logic                      vis_first, vis_next;

  // A pixel is emitted only when on screen and not dashed off
  function automatic logic visible(input logic [COORD_W-1:0] x,
                                   input logic [COORD_W-1:0] y,
                                   input logic               dash,
                                   input logic               bit0);
    return (32'(x) < X_LIM) && (32'(y) < Y_LIM) && (!dash || bit0);
  endfunction

  // Setup deltas and the next Bresenham step derived from the current error
  always_comb begin
    setup_dx = (x1_q >= x0_q) ? ({1'b0, x1_q} - {1'b0, x0_q})
                              : ({1'b0, x0_q} - {1'b0, x1_q});
    setup_dy = (y1_q >= y0_q) ? ({1'b0, y1_q} - {1'b0, y0_q})
                              : ({1'b0, y0_q} - {1'b0, y1_q});

    e2      = $signed({err_q, 1'b0});
    dx_wide = $signed({2'b00, dx_q});
    neg_dy  = -$signed({2'b00, dy_q});
    dx_s    = $signed({1'b0, dx_q});
    dy_s    = $signed({1'b0, dy_q});

    // Both decisions use the error from before this step
    go_x = (e2 > neg_dy);
    go_y = (e2 < dx_wide);

    next_err = err_q;
    next_x   = cur_x;
    next_y   = cur_y;
    if (go_x) begin
      next_err = next_err - dy_s;
      next_x   = sx_neg ? (cur_x - COORD_W'(1)) : (cur_x + COORD_W'(1));
    end
    if (go_y) begin
      next_err = next_err + dx_s;
      next_y   = sy_neg ? (cur_y - COORD_W'(1)) : (cur_y + COORD_W'(1));
    end

    pat_rot = {pat_q[0], pat_q[PAT_W-1:1]};
    at_end  = (cur_x == x1_q) && (cur_y == y1_q);
    in_xfc  = cmd.in_rts && in_rtr_q && (state == IDLE);
    // A hidden pixel advances every cycle; a visible one waits for its transfer
    step_ev = (state == STEP) && (!out_rts_q || pix.out_rtr);

    vis_first = visible(x0_q, y0_q, dash_q, pat_q[0]);
    vis_next  = visible(next_x, next_y, dash_q, pat_rot[0]);
  end

  // Control FSM; out_rts is precomputed for the pixel about to be presented
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      color_q   <= '0;
      pat_q     <= '0;
      dash_q    <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      err_q     <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      out_rts_q <= 1'b0;
      in_rtr_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfc) begin
            x0_q     <= cmd.x0_in;
            y0_q     <= cmd.y0_in;
            x1_q     <= cmd.x1_in;
            y1_q     <= cmd.y1_in;
            color_q  <= cmd.color_in;
            pat_q    <= cmd.pattern_in;
            dash_q   <= cmd.dash_en;
            in_rtr_q <= 1'b0;
            busy_q   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          dx_q      <= setup_dx;
          dy_q      <= setup_dy;
          sx_neg    <= (x1_q < x0_q);
          sy_neg    <= (y1_q < y0_q);
          err_q     <= $signed({1'b0, setup_dx}) - $signed({1'b0, setup_dy});
          cur_x     <= x0_q;
          cur_y     <= y0_q;
          out_rts_q <= vis_first;
          state     <= STEP;
        end
        STEP: begin
          if (step_ev) begin
            pat_q <= pat_rot;
            if (at_end) begin
              out_rts_q <= 1'b0;
              done_q    <= 1'b1;
              state     <= DONE;
            end else begin
              cur_x     <= next_x;
              cur_y     <= next_y;
              err_q     <= next_err;
              out_rts_q <= vis_next;
            end
          end
        end
        DONE: begin
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          in_rtr_q <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd.in_rtr    = in_rtr_q;
  assign pix.out_rts   = out_rts_q;
  assign pix.draw_x    = cur_x;
  assign pix.draw_y    = cur_y;
  assign pix.color_out = color_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

`default_nettype wire

// File: doc/line_raster.md
Name: line_raster

Overview:
- Parametrised successor to the current line drawer.
- Rasterises one line segment per input transfer using all-octant integer Bresenham, and emits pixel coordinates plus colour on a ready/ready handshake.
- Adds configurable coordinate and colour widths, screen-bounds clipping, and an optional 16-bit dash pattern.
- Sits between the command decoder and the framebuffer write arbiter.

Parameters:
- COORD_W, 10, width of every coordinate port and of the internal position registers.
- COLOR_W, 12, width of the colour ports.
- SCREEN_W, 640, pixels with x >= SCREEN_W are clipped (not emitted).
- SCREEN_H, 480, pixels with y >= SCREEN_H are clipped.
- PAT_W, 16, dash pattern width.

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- x0_in, y0_in  in  COORD_W each  start point (unsigned)
- x1_in, y1_in  in  COORD_W each  end point (unsigned)
- color_in  in  COLOR_W  line colour
- pattern_in  in  PAT_W  dash pattern; bit 0 applies to the first pixel
- dash_en  in  1  1 = apply pattern, 0 = solid line
- in_rts  in  1  command valid
- in_rtr  out  1  ready for a command
- out_rts  out  1  pixel valid
- out_rtr  in  1  downstream ready
- draw_x, draw_y  out  COORD_W each  pixel coordinate
- color_out  out  COLOR_W  held colour
- busy  out  1  high from accept until DONE exits
- done  out  1  one-cycle pulse in DONE state

Behaviour:
- One clock, clk; reset rst_ is asynchronous, active-low.
- Reset values:
  - state = IDLE; draw_x, draw_y, color_out = 0.
  - All internal holds, error and pattern registers = 0.
  - in_rtr = 1; out_rts, busy, done = 0.
- Transfers complete on rts & rtr in the same cycle. in_xfc = in_rts & in_rtr. out_xfc = out_rts & out_rtr.
- States: IDLE, SETUP, STEP, DONE.
- IDLE:
  - in_rtr = 1.
  - On in_xfc, latch endpoints, color_in, pattern_in and dash_en, then go to SETUP.
- SETUP (1 cycle):
  - dx = |x1 - x0| and dy = |y1 - y0|, COORD_W+1 bits unsigned.
  - sx = +1 if x1 >= x0, else -1. sy likewise.
  - err = dx - dy, signed COORD_W+2 bits.
  - draw_x = x0, draw_y = y0.
  - Go to STEP.
- STEP:
  - The current pixel is visible when draw_x < SCREEN_W, draw_y < SCREEN_H, and (!dash_en or pat[0]).
  - out_rts = visible. A stepping event is out_xfc when visible, or every cycle when not visible; a hidden pixel costs 1 cycle and no transfer.
  - While out_rts = 1 and out_rtr = 0, draw_x, draw_y and color_out hold stable.
  - Terminal check on a stepping event: if draw_x == x1 and draw_y == y1, go to DONE. The endpoint is included.
  - Otherwise, with e2 = 2*err:
    - if e2 > -dy: err -= dy, draw_x += sx;
    - if e2 < dx: err += dx, draw_y += sy.
    - Both updates apply in the same cycle when both conditions hold (diagonal step).
  - On every stepping event, pat rotates right by 1 (bit 0 -> bit PAT_W-1), including for clipped or dashed-off pixels.
- DONE (1 cycle): done = 1, busy = 0 next cycle, go to IDLE. in_rtr is 0 in DONE.
- Degenerate line (x0 == x1 and y0 == y1): exactly one pixel considered, then DONE.
- Coordinate arithmetic never wraps. The Bresenham walk stays within the endpoint bounding box, so draw_x and draw_y remain within [min, max] of the endpoints.
- Throughput: 1 pixel per cycle when out_rtr is held high.
- Latency: in_xfc to first out_rts is 2 cycles (SETUP, then STEP).
- Reset mid-line: immediate return to IDLE, out_rts drops asynchronously, and no further pixels are emitted.
- in_rts while busy is ignored (in_rtr = 0); the command is neither lost nor latched.

Test Plan:
- (0,0)->(5,2), solid, out_rtr=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2), then one done pulse; 6 transfers.
- (7,3)->(3,9), steep, negative x -> 7 pixels, draw_y strictly increasing 3..9, draw_x non-increasing 7..3, last pixel (3,9).
- (638,10)->(642,10), SCREEN_W=640 -> only (638,10),(639,10) emitted; done asserts 3 cycles after the last transfer.
- (0,0)->(7,0), dash_en=1, pattern=16'h0033 -> x = 0,1,4,5 emitted; x = 2,3,6,7 skipped.
- Random out_rtr backpressure on (0,0)->(20,13) -> sequence identical to the out_rtr=1 run; outputs stable while stalled.
- Assert rst_ low during STEP of a 100-pixel line -> out_rts and busy go to 0 immediately. After release, in_rtr = 1 and a new command starts cleanly at its own x0,y0.
